// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: bit-serial unsigned magnitude-compare sequencer, one bit per clock.
// Define COMP_SEQ_EARLY_EXIT_EN for an MSB-first scan that finishes at the first differing bit.
module comp_seq_ctrl #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         lg_out_o,
   output logic         eq_out_o,
   output logic         rg_out_o,
   output logic [W-1:0] max_out_o
);
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t        state_q;
   logic [W-1:0]  x_q, y_q;
   logic [CW-1:0] cnt_q, idx;
   logic [2:0]    flags_q, flags_d;
   logic          bx, by, last, accept;
`ifdef COMP_SEQ_EARLY_EXIT_EN
   assign idx  = LAST - cnt_q;
   assign last = (cnt_q == LAST) || (bx != by);
`else
   assign idx  = cnt_q;
   assign last = cnt_q == LAST;
`endif
   assign bx      = x_q[idx];
   assign by      = y_q[idx];
   assign flags_d = (bx & ~by) ? 3'b100 : (~bx & by) ? 3'b001 : flags_q;
   assign accept  = start_i && state_q != RUN;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         cnt_q     <= '0;
         flags_q   <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         lg_out_o  <= 1'b0;
         eq_out_o  <= 1'b0;
         rg_out_o  <= 1'b0;
         max_out_o <= '0;
      end else begin
         done_o <= 1'b0;
         if (accept) begin
            x_q     <= x_i;
            y_q     <= y_i;
            cnt_q   <= '0;
            flags_q <= 3'b010;
            busy_o  <= 1'b1;
            state_q <= RUN;
         end else if (state_q == RUN) begin
            flags_q <= flags_d;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
               {lg_out_o, eq_out_o, rg_out_o} <= flags_d;
               max_out_o <= flags_d[0] ? y_q : x_q;
               done_o    <= 1'b1;
               busy_o    <= 1'b0;
               state_q   <= FIN;
            end
         end else begin
            state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl: random and directed stimulus against a latency-countdown reference model.
module tb_comp_seq_ctrl;
   localparam int W = 8;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] x = '0, y = '0;
   logic         busy, done, lg, eq, rg;
   logic [W-1:0] mx;
   int           checks = 0, errors = 0, ndone = 0, base;
   logic         prev_done = 1'b0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_lg = 1'b0, m_eq = 1'b0, m_rg = 1'b0;
   logic [W-1:0] m_max = '0, p_max = '0;
   logic [2:0]   p_res = '0;
   int           m_rem = 0;

   always #5 clk = ~clk;

   comp_seq_ctrl #(.W(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .y_i(y),
      .busy_o(busy), .done_o(done), .lg_out_o(lg), .eq_out_o(eq), .rg_out_o(rg),
      .max_out_o(mx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @%0t got=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMP_SEQ_EARLY_EXIT_EN
      for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) return W - i;
`endif
      return W;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; {m_lg, m_eq, m_rg} = 3'b000; m_max = '0; m_rem = 0;
      end else begin
         m_done = 1'b0;
         if (start && !m_busy) begin
            p_res  = {x > y, x == y, x < y};
            p_max  = (x >= y) ? x : y;
            m_rem  = lat(x, y);
            m_busy = 1'b1;
         end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               {m_lg, m_eq, m_rg} = p_res;
               m_max  = p_max;
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      rst = r; start = s; x = a; y = b;
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("outs", 64'({busy, done, lg, eq, rg, mx}), 64'({m_busy, m_done, m_lg, m_eq, m_rg, m_max}));
      if (done) begin
         ndone++;
         chk("onehot", 64'($countones({lg, eq, rg})), 64'd1);
         chk("done_pulse", 64'(prev_done), 64'd0);
      end
      prev_done = done;
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int idle);
      cyc(1'b0, 1'b1, a, b);
      for (int i = 0; i < idle; i++) cyc(1'b0, 1'b0, 8'hFF ^ a, b);
   endtask

   initial begin
      cyc(1'b1, 1'b0, '0, '0);
      cyc(1'b1, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, '0, '0);
      chk("reset", 64'({busy, done, lg, eq, rg, mx}), 64'd0);
      op(8'hA5, 8'h5A, 10);
      chk("t1_lg_max", 64'({lg, mx}), 64'({1'b1, 8'hA5}));
      op(8'h3C, 8'h3C, 10);
      chk("t2_eq", 64'({eq, mx}), 64'({1'b1, 8'h3C}));
      op(8'h01, 8'h80, 10);
      chk("t2_rg", 64'({rg, mx}), 64'({1'b1, 8'h80}));
      base = ndone;
      cyc(1'b0, 1'b1, 8'h10, 8'h0F);
      cyc(1'b0, 1'b0, 8'h10, 8'h0F);
      cyc(1'b0, 1'b0, 8'h10, 8'h0F);
      cyc(1'b0, 1'b1, 8'hFF, 8'h0F);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'hFF, 8'h00);
      chk("t3_ndone", 64'(ndone - base), 64'd1);
      chk("t3_lg_max", 64'({lg, mx}), 64'({1'b1, 8'h10}));
      base = ndone;
      for (int i = 0; i < 27; i++) cyc(1'b0, 1'b1, 8'h02, 8'h03);
      cyc(1'b0, 1'b0, 8'h02, 8'h03);
      chk("t4_rg", 64'({rg, mx}), 64'({1'b1, 8'h03}));
      chk("t4_ndone_min", 64'(ndone - base >= 3), 64'd1);
      op(8'hF0, 8'h0F, 3);
      cyc(1'b1, 1'b0, 8'hF0, 8'h0F);
      chk("t5_abort", 64'({busy, done, lg, eq, rg, mx}), 64'd0);
      op(8'hF0, 8'h0F, 10);
      chk("t5_next", 64'({lg, mx}), 64'({1'b1, 8'hF0}));
      op(8'h80, 8'h7F, 10);
      op(8'h09, 8'h08, 10);
      op(8'h55, 8'h55, 10);
      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] a, b;
         int sel;
         a = W'($urandom);
         sel = $urandom_range(0, 3);
         b = (sel == 0) ? a : (sel == 1) ? a ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
         cyc(1'b0 || ($urandom_range(0, 99) == 0), $urandom_range(0, 2) == 0, a, b);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
